// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues regfile-based commands to an external ALU, writes back and returns results
module alu_issue_ctrl #(
  parameter int ALU_LAT = 0,
  parameter int NREG = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [2:0]  cmd_rd,
  input  logic [2:0]  cmd_rs1,
  input  logic [2:0]  cmd_rs2,
  input  logic        cmd_imm_sel,
  input  logic [31:0] cmd_imm,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [2:0]  rsp_rd,
  input  logic [2:0]  dbg_addr,
  output logic [31:0] dbg_data
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt;
  logic [2:0] rd_q;
  logic [31:0] regs [NREG];
  logic [31:0] rs1_val, rs2_val;
  logic accept, cap;
  assign rs1_val = cmd_rs1 == 3'd0 ? 32'd0 : regs[cmd_rs1];
  assign rs2_val = cmd_rs2 == 3'd0 ? 32'd0 : regs[cmd_rs2];
  assign dbg_data = dbg_addr == 3'd0 ? 32'd0 : regs[dbg_addr];
  assign accept = cmd_valid && cmd_ready;
  assign cap = state == WAIT && cnt == 4'd0;
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_nxt;
  always_comb begin
    cmd_ready = state == IDLE;
    state_nxt = state == IDLE ? (cmd_valid ? WAIT : IDLE) :
                state == WAIT ? (cnt == 4'd0 ? RESP : WAIT) :
                state == RESP ? (rsp_ready ? IDLE : RESP) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_op <= '0;
      rd_q <= '0;
      cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_rd <= '0;
    end else begin
      if (accept) begin
        alu_a <= rs1_val;
        alu_b <= cmd_imm_sel ? cmd_imm : rs2_val;
        alu_op <= cmd_op;
        rd_q <= cmd_rd;
        cnt <= 4'(ALU_LAT);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (cap) begin
        rsp_data <= alu_result;
        rsp_rd <= rd_q;
        rsp_valid <= 1'b1;
        if (rd_q != 3'd0) regs[rd_q] <= alu_result;
      end else if (rsp_valid && (rsp_ready || state != RESP)) begin
        rsp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed checks of alu_issue_ctrl with ALU_LAT=0 and ALU_LAT=3 instances
module tb_alu_issue_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst0_n, rst3_n, v0, v3, rdy0, rdy3, rv0, rv3;
  logic [2:0] cmd_op, cmd_rd, cmd_rs1, cmd_rs2, dbg_addr;
  logic cmd_imm_sel, rsp_ready;
  logic [31:0] cmd_imm;
  logic [31:0] a0, b0, res0, dat0, dbg0, a3, b3, res3, dat3, dbg3;
  logic [2:0] op0, rrd0, op3, rrd3;
  int checks = 0;
  int failures = 0;
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return {31'd0, a < b};
      3'd6: return {31'd0, a > b};
      default: return {31'd0, a == b};
    endcase
  endfunction
  assign res0 = alu_f(a0, b0, op0);
  assign res3 = alu_f(a3, b3, op3);
  alu_issue_ctrl #(.ALU_LAT(0)) u0 (
    .clk(clk), .rst_n(rst0_n), .cmd_valid(v0), .cmd_ready(rdy0), .cmd_op(cmd_op), .cmd_rd(cmd_rd),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm_sel(cmd_imm_sel), .cmd_imm(cmd_imm),
    .alu_a(a0), .alu_b(b0), .alu_op(op0), .alu_result(res0), .rsp_valid(rv0), .rsp_ready(rsp_ready),
    .rsp_data(dat0), .rsp_rd(rrd0), .dbg_addr(dbg_addr), .dbg_data(dbg0)
  );
  alu_issue_ctrl #(.ALU_LAT(3)) u3 (
    .clk(clk), .rst_n(rst3_n), .cmd_valid(v3), .cmd_ready(rdy3), .cmd_op(cmd_op), .cmd_rd(cmd_rd),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm_sel(cmd_imm_sel), .cmd_imm(cmd_imm),
    .alu_a(a3), .alu_b(b3), .alu_op(op3), .alu_result(res3), .rsp_valid(rv3), .rsp_ready(rsp_ready),
    .rsp_data(dat3), .rsp_rd(rrd3), .dbg_addr(dbg_addr), .dbg_data(dbg3)
  );
  task automatic drive(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic isel, input logic [31:0] imm);
    cmd_op = op;
    cmd_rd = rd;
    cmd_rs1 = rs1;
    cmd_rs2 = rs2;
    cmd_imm_sel = isel;
    cmd_imm = imm;
  endtask
  task automatic run0(input string nm, input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                      input logic [2:0] rs2, input logic isel, input logic [31:0] imm, input logic [31:0] exp);
    @(negedge clk);
    drive(op, rd, rs1, rs2, isel, imm);
    v0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0;
    drive(3'd7, 3'd7, 3'd7, 3'd7, 1'b1, 32'hDEAD_BEEF);
    checks++;
    if ({rv0, rdy0} !== 2'b00) begin
      failures++;
      $display("FAIL %s wait: rsp_valid=%b cmd_ready=%b required 0 0", nm, rv0, rdy0);
    end
    @(negedge clk);
    checks++;
    if ({rv0, rdy0, rrd0, dat0} !== {1'b1, 1'b0, rd, exp}) begin
      failures++;
      $display("FAIL %s rsp: valid=%b ready=%b rd=%0d data=%h required 1 0 %0d %h", nm, rv0, rdy0, rrd0, dat0, rd, exp);
    end
    @(negedge clk);
    checks++;
    if ({rv0, rdy0} !== 2'b01) begin
      failures++;
      $display("FAIL %s idle: rsp_valid=%b cmd_ready=%b required 0 1", nm, rv0, rdy0);
    end
  endtask
  task automatic chk_dbg(input string nm, input logic [2:0] addr, input logic [31:0] exp);
    dbg_addr = addr;
    #1;
    checks++;
    if (dbg0 !== exp) begin
      failures++;
      $display("FAIL %s: dbg_data=%h required %h", nm, dbg0, exp);
    end
  endtask
  task automatic test_reset;
    rst0_n = 1'b0;
    rst3_n = 1'b0;
    repeat (3) @(negedge clk);
    rst0_n = 1'b1;
    rst3_n = 1'b1;
    checks++;
    if ({rdy0, rv0, dat0, rrd0, a0, b0, op0} !== {1'b1, 1'b0, 32'd0, 3'd0, 32'd0, 32'd0, 3'd0}) begin
      failures++;
      $display("FAIL reset0: ready=%b valid=%b data=%h rd=%0d a=%h b=%h op=%0d required 1 0 0 0 0 0 0",
               rdy0, rv0, dat0, rrd0, a0, b0, op0);
    end
    checks++;
    if ({rdy3, rv3, dat3} !== {1'b1, 1'b0, 32'd0}) begin
      failures++;
      $display("FAIL reset3: ready=%b valid=%b data=%h required 1 0 0", rdy3, rv3, dat3);
    end
    chk_dbg("reset_dbg_r5", 3'd5, 32'd0);
  endtask
  task automatic test_add_wrap;
    run0("add_imm5", 3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 32'd5, 32'd5);
    run0("add_wrap", 3'd0, 3'd2, 3'd1, 3'd0, 1'b1, 32'hFFFF_FFFF, 32'd4);
    chk_dbg("dbg_r2", 3'd2, 32'd4);
  endtask
  task automatic test_sub_latency;
    run0("sub_underflow", 3'd1, 3'd3, 3'd0, 3'd0, 1'b1, 32'd1, 32'hFFFF_FFFF);
    checks++;
    if ({a0, b0, op0} !== {32'd0, 32'd1, 3'd1}) begin
      failures++;
      $display("FAIL alu_hold: a=%h b=%h op=%0d required 0 1 1", a0, b0, op0);
    end
  endtask
  task automatic test_compare;
    run0("load_r4", 3'd1, 3'd4, 3'd0, 3'd0, 1'b1, 32'd1, 32'hFFFF_FFFF);
    run0("slt_unsigned", 3'd5, 3'd5, 3'd4, 3'd0, 1'b1, 32'd1, 32'd0);
    run0("sgt_unsigned", 3'd6, 3'd6, 3'd4, 3'd0, 1'b1, 32'd1, 32'd1);
    run0("seq_regs", 3'd7, 3'd7, 3'd4, 3'd4, 1'b0, 32'd0, 32'd1);
    run0("or_regs", 3'd3, 3'd5, 3'd2, 3'd6, 1'b0, 32'd0, 32'd5);
    run0("and_regs", 3'd2, 3'd6, 3'd4, 3'd2, 1'b0, 32'd0, 32'd4);
    chk_dbg("dbg_r6", 3'd6, 32'd4);
  endtask
  task automatic test_hazard;
    run0("add_self", 3'd0, 3'd1, 3'd1, 3'd1, 1'b0, 32'd0, 32'd10);
    chk_dbg("dbg_r1", 3'd1, 32'd10);
  endtask
  task automatic test_backpressure;
    rsp_ready = 1'b0;
    @(negedge clk);
    drive(3'd0, 3'd5, 3'd1, 3'd0, 1'b1, 32'd2);
    v0 = 1'b1;
    @(negedge clk);
    drive(3'd4, 3'd6, 3'd6, 3'd6, 1'b1, 32'h1234_5678);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rv0, rdy0, rrd0, dat0} !== {1'b1, 1'b0, 3'd5, 32'd12}) begin
        failures++;
        $display("FAIL hold_%0d: valid=%b ready=%b rd=%0d data=%h required 1 0 5 0000000c", i, rv0, rdy0, rrd0, dat0);
      end
      @(negedge clk);
    end
    v0 = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({rv0, rdy0} !== 2'b01) begin
      failures++;
      $display("FAIL release: rsp_valid=%b cmd_ready=%b required 0 1", rv0, rdy0);
    end
    chk_dbg("dbg_r5", 3'd5, 32'd12);
    chk_dbg("dbg_r6_untouched", 3'd6, 32'd4);
  endtask
  task automatic test_r0_write;
    run0("xor_r0", 3'd4, 3'd0, 3'd0, 3'd0, 1'b1, 32'hA5, 32'hA5);
    chk_dbg("dbg_r0", 3'd0, 32'd0);
  endtask
  task automatic test_lat3_reset;
    @(negedge clk);
    drive(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 32'd9);
    v3 = 1'b1;
    @(negedge clk);
    v3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({rv3, rdy3} !== 2'b00) begin
        failures++;
        $display("FAIL lat3_wait_%0d: rsp_valid=%b cmd_ready=%b required 0 0", i, rv3, rdy3);
      end
      @(negedge clk);
    end
    checks++;
    if ({rv3, rrd3, dat3} !== {1'b1, 3'd1, 32'd9}) begin
      failures++;
      $display("FAIL lat3_rsp: valid=%b rd=%0d data=%h required 1 1 00000009", rv3, rrd3, dat3);
    end
    @(negedge clk);
    drive(3'd0, 3'd2, 3'd0, 3'd0, 1'b1, 32'h33);
    v3 = 1'b1;
    @(negedge clk);
    v3 = 1'b0;
    @(negedge clk);
    rst3_n = 1'b0;
    @(negedge clk);
    rst3_n = 1'b1;
    checks++;
    if ({rdy3, rv3, a3} !== {1'b1, 1'b0, 32'd0}) begin
      failures++;
      $display("FAIL lat3_abort: ready=%b valid=%b a=%h required 1 0 0", rdy3, rv3, a3);
    end
    dbg_addr = 3'd2;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({rv3, dbg3} !== {1'b0, 32'd0}) begin
        failures++;
        $display("FAIL lat3_no_rsp_%0d: valid=%b r2=%h required 0 0", i, rv3, dbg3);
      end
    end
  endtask
  initial begin
    v0 = 1'b0;
    v3 = 1'b0;
    rsp_ready = 1'b1;
    dbg_addr = 3'd0;
    drive(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 32'd0);
    test_reset;
    test_add_wrap;
    test_sub_latency;
    test_compare;
    test_hazard;
    test_backpressure;
    test_r0_write;
    test_lat3_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator-side controller for the team's combinational 32-bit ALU.
- Accepts register-based commands over a valid/ready port and reads operands from an internal 8x32 register file.
- Drives the ALU's a/b/op inputs, samples its result after a fixed latency, writes the result back, and returns it over a valid/ready response port.
- Sits between the command source (test sequencer or future decode stage) and the ALU.

Parameters:
- ALU_LAT, 0: extra cycles to wait after driving the ALU before sampling alu_result. Range 0..15.
- NREG, 8: register file depth. Fixed at 8 because of the 3-bit register indices.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  3  ALU op: ADD=000, SUB=001, AND=010, OR=011, XOR=100, SLT=101, SGT=110, SEQ=111.
- cmd_rd  in  3  destination register.
- cmd_rs1  in  3  source register for operand a.
- cmd_rs2  in  3  source register for operand b when cmd_imm_sel=0.
- cmd_imm_sel  in  1  1: operand b = cmd_imm.
- cmd_imm  in  32  immediate operand.
- alu_a  out  32  registered operand a to the ALU.
- alu_b  out  32  registered operand b to the ALU.
- alu_op  out  3  registered opcode to the ALU.
- alu_result  in  32  ALU result (combinational in alu_a/alu_b/alu_op).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  32  captured result.
- rsp_rd  out  3  destination register of the response.
- dbg_addr  in  3  debug read index.
- dbg_data  out  32  combinational read of regfile[dbg_addr]; returns 0 for index 0.

Behaviour:
- Interface decision: one clock (clk); reset rst_n is synchronous and active-low. Polarity and synchronicity are fixed.
- Reset (rst_n=0 at an edge):
  - All regfile entries = 0.
  - alu_a = 0, alu_b = 0, alu_op = 000.
  - rsp_valid = 0, rsp_data = 0, rsp_rd = 0.
  - Wait counter = 0; state = IDLE, so cmd_ready = 1 after the reset edge.
  - Reset mid-operation aborts the command: no writeback, no response.
- Register 0 is hardwired zero: reads return 0 and writes are discarded. A response is still issued for rd=0.
- FSM:
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready:
    - alu_a <= R[rs1]; alu_b <= (imm_sel ? imm : R[rs2]); alu_op <= cmd_op; latch rd.
    - counter <= ALU_LAT; go to WAIT.
  - WAIT: cmd_ready=0. If counter != 0, decrement. Otherwise:
    - rsp_data <= alu_result; rsp_rd <= latched rd; rsp_valid <= 1.
    - R[rd] <= alu_result if rd != 0.
    - Go to RESP.
  - RESP: cmd_ready=0; rsp_valid held at 1 and rsp_data/rsp_rd held stable until rsp_valid&&rsp_ready. On that edge: rsp_valid <= 0, go to IDLE.
- Latency:
  - rsp_valid rises 1+ALU_LAT cycles after the accept edge.
  - Minimum command spacing is 3+ALU_LAT cycles with rsp_ready tied high.
- alu_a/alu_b/alu_op change only on the accept edge. They are held through WAIT and RESP.
- Writeback happens at the capture edge. The next accepted command reads the updated value (no hazard).
- Operand read of rs1=rs2=rd in the same command uses the pre-write value.
- cmd_* fields are ignored when not accepted. cmd_valid may drop without being accepted.
- rsp_ready asserted while rsp_valid=0 has no effect.
- Arithmetic is done by the external ALU and is modulo 2^32. SLT, SGT and SEQ are unsigned comparisons returning 0 or 1.
- Illegal or unknown states recover to IDLE.

Test Plan:
- Reset then ADD imm: R1 = ADD(R0, imm 5), then ADD R2 = R1 + imm 0xFFFFFFFF -> rsp_data = 5, then 4 (wrap). dbg R2 = 4.
- SUB underflow with ALU_LAT=0: R3 = SUB(R0, imm 1) -> rsp_data = 0xFFFFFFFF. rsp_valid exactly 1 cycle after accept. cmd_ready low for WAIT and RESP.
- Unsigned compares: R4 = 0xFFFFFFFF. SLT(R4, imm 1) -> 0; SGT(R4, imm 1) -> 1; SEQ(R4, R4) -> 1.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data and rsp_rd stable and cmd_ready=0 throughout; accept on the first cycle rsp_ready=1.
- Write to R0: XOR rd=0 with imm 0xA5 -> rsp_data = 0xA5, rsp_rd = 0, dbg R0 = 0.
- ALU_LAT=3 plus reset: rsp_valid rises at accept+4. Assert rst_n=0 during WAIT -> no response, target register unchanged (0), cmd_ready=1 after reset.
